// File: rtl/zeroriscy_fetch_ctrl.sv
// Instruction-fetch sequencer: issues word-aligned fetches with one transaction
// in flight, drops responses of streams abandoned by a branch, and feeds the fetch FIFO.
module zeroriscy_fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    output logic        busy_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_GNT     = 2'd1;
    localparam logic [1:0] WAIT_RVALID  = 2'd2;
    localparam logic [1:0] WAIT_ABORTED = 2'd3;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [31:0] fetch_addr_r;
    logic [31:0] fetch_addr_next_s;
    logic [31:0] rsp_addr_r;
    logic [31:0] rsp_addr_next_s;
    logic [31:0] eff_addr_s;
    logic [31:0] seq_addr_s;
    logic        allowed_s;
    logic        req_s;
    logic        valid_s;

    // A branch overrides the stored address in the same cycle it arrives.
    assign eff_addr_s = branch_i ? addr_i : fetch_addr_r;
    assign seq_addr_s = {eff_addr_s[31:2], 2'b00} + 32'd4;
    assign allowed_s  = branch_i | (req_i & fifo_ready_i);

    assign busy_o       = (state_r != IDLE);
    assign instr_req_o  = req_s;
    assign instr_addr_o = {eff_addr_s[31:2], 2'b00};
    assign fifo_clear_o = branch_i;
    assign fifo_valid_o = valid_s;
    assign fifo_addr_o  = rsp_addr_r;
    assign fifo_rdata_o = instr_rdata_i;

    // Next-state, request and push decode.
    always_comb begin
        state_next_s      = state_r;
        fetch_addr_next_s = fetch_addr_r;
        rsp_addr_next_s   = rsp_addr_r;
        req_s             = 1'b0;
        valid_s           = 1'b0;

        case (state_r)
            IDLE: begin
                req_s = allowed_s;
            end
            WAIT_GNT: begin
                req_s = 1'b1;
            end
            WAIT_RVALID: begin
                if (instr_rvalid_i) begin
                    req_s        = allowed_s;
                    valid_s      = ~branch_i;
                    state_next_s = IDLE;
                end else if (branch_i) begin
                    state_next_s      = WAIT_ABORTED;
                    fetch_addr_next_s = addr_i;
                end else begin
                    state_next_s = WAIT_RVALID;
                end
            end
            WAIT_ABORTED: begin
                // The redirect target is pending, so the request is forced once the stale word lands.
                if (instr_rvalid_i) begin
                    req_s = 1'b1;
                end else if (branch_i) begin
                    fetch_addr_next_s = addr_i;
                end else begin
                    fetch_addr_next_s = fetch_addr_r;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (req_s) begin
            if (instr_gnt_i) begin
                rsp_addr_next_s   = eff_addr_s;
                fetch_addr_next_s = seq_addr_s;
                state_next_s      = WAIT_RVALID;
            end else begin
                fetch_addr_next_s = eff_addr_s;
                state_next_s      = WAIT_GNT;
            end
        end else begin
            rsp_addr_next_s = rsp_addr_r;
        end
    end

    // State and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            fetch_addr_r <= 32'h0000_0000;
            rsp_addr_r   <= 32'h0000_0000;
        end else begin
            state_r      <= state_next_s;
            fetch_addr_r <= fetch_addr_next_s;
            rsp_addr_r   <= rsp_addr_next_s;
        end
    end

endmodule

// File: tb/tb_zeroriscy_fetch_ctrl.sv
// Randomized and directed bench for zeroriscy_fetch_ctrl against a transaction-level
// model of the fetch stream (outstanding word, live/aborted, pending request).
module tb_zeroriscy_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        branch;
    logic [31:0] addr;
    logic        busy;
    logic        ireq;
    logic [31:0] iaddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        clear;
    logic        fvalid;
    logic [31:0] faddr;
    logic [31:0] frdata;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the fetch stream.
    logic        m_out;
    logic        m_live;
    logic [31:0] m_oaddr;
    logic [31:0] m_fetch;
    logic        m_pend;
    logic        m_tgt;

    zeroriscy_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req),
        .branch_i      (branch),
        .addr_i        (addr),
        .busy_o        (busy),
        .instr_req_o   (ireq),
        .instr_addr_o  (iaddr),
        .instr_gnt_i   (gnt),
        .instr_rvalid_i(rvalid),
        .instr_rdata_i (rdata),
        .fifo_ready_i  (ready),
        .fifo_clear_o  (clear),
        .fifo_valid_o  (fvalid),
        .fifo_addr_o   (faddr),
        .fifo_rdata_o  (frdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_live = 1'b0; m_oaddr = 32'h0; m_fetch = 32'h0;
        m_pend = 1'b0; m_tgt = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare DUT with the model, advance the model.
    task automatic tick(input logic br, input logic [31:0] ad, input logic rq,
                        input logic gn, input logic rv, input logic rdy);
        logic        e_valid;
        logic        e_req;
        logic [31:0] eff;
        @(negedge clk);
        branch = br; addr = ad; req = rq; gnt = gn; rvalid = rv; ready = rdy;
        rdata  = $urandom;
        #2;
        eff     = br ? ad : m_fetch;
        e_valid = m_out && m_live && rv && !br;
        if (m_out && !rv)        e_req = 1'b0;
        else if (m_pend || m_tgt) e_req = 1'b1;
        else                      e_req = br | (rq & rdy);
        chk("instr_req", {31'd0, ireq}, {31'd0, e_req});
        chk("instr_addr", iaddr, {eff[31:2], 2'b00});
        chk("fifo_valid", {31'd0, fvalid}, {31'd0, e_valid});
        chk("fifo_clear", {31'd0, clear}, {31'd0, br});
        chk("busy", {31'd0, busy}, {31'd0, (m_out | m_pend)});
        if (e_valid) begin
            chk("fifo_addr", faddr, m_oaddr);
            chk("fifo_rdata", frdata, rdata);
        end
        if (m_out && !rv && br) begin
            m_live = 1'b0; m_tgt = 1'b1; m_fetch = ad;
        end
        if (m_out && rv) m_out = 1'b0;
        if (e_req) begin
            if (gn) begin
                m_out = 1'b1; m_live = 1'b1; m_oaddr = eff;
                m_fetch = {eff[31:2], 2'b00} + 32'd4;
                m_pend = 1'b0; m_tgt = 1'b0;
            end else begin
                m_pend = 1'b1; m_tgt = 1'b0; m_fetch = eff;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; branch = 1'b0; addr = 32'h0; req = 1'b0; gnt = 1'b0;
        rvalid = 1'b0; ready = 1'b0; rdata = 32'h0;
        #2;
        model_reset();
        chk("rst_req", {31'd0, ireq}, 32'd0);
        chk("rst_valid", {31'd0, fvalid}, 32'd0);
        chk("rst_clear", {31'd0, clear}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_faddr", faddr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; addr = 32'h0; req = 1'b0; gnt = 1'b0;
        rvalid = 1'b0; ready = 1'b0; rdata = 32'h0;
        model_reset();
        do_reset();

        // Boot branch to 0x80, back-to-back grant/rvalid.
        tick(1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("boot_req", {31'd0, ireq}, 32'd1);
        chk("boot_addr", iaddr, 32'h80);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("push0", faddr, 32'h80);
        chk("seq_addr", iaddr, 32'h84);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("push1", faddr, 32'h84);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("push2", faddr, 32'h88);

        // Branch to a compressed target with rvalid in the same cycle.
        tick(1'b1, 32'h102, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("br_drop", {31'd0, fvalid}, 32'd0);
        chk("br_iaddr", iaddr, 32'h100);
        chk("br_clear", {31'd0, clear}, 32'd1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("c_push0", faddr, 32'h102);
        chk("c_iaddr", iaddr, 32'h104);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("c_push1", faddr, 32'h104);

        // Grant withheld for 5 cycles, retarget in the third.
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("gnt_wait1", iaddr, 32'h108);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("gnt_wait2", iaddr, 32'h108);
        tick(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("gnt_retarget", iaddr, 32'h200);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("gnt_hold", iaddr, 32'h200);
        chk("gnt_hold_req", {31'd0, ireq}, 32'd1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);

        // Branch while waiting for rvalid; rvalid arrives 3 cycles later.
        tick(1'b1, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("abort_req", {31'd0, ireq}, 32'd0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_drop", {31'd0, fvalid}, 32'd0);
        chk("abort_iaddr", iaddr, 32'h300);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_push", faddr, 32'h300);

        // FIFO not ready for 4 cycles.
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("nr_push", faddr, 32'h304);
        chk("nr_req", {31'd0, ireq}, 32'd0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("nr_resume", iaddr, 32'h308);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("nr_push2", faddr, 32'h308);

        // Address wrap at the top of memory.
        tick(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("wrap_addr", iaddr, 32'h0);
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("wrap_push", faddr, 32'h0);

        // Reset mid-transaction, then a late rvalid.
        tick(1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 1'b1);
        do_reset();
        tick(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("late_rvalid", {31'd0, fvalid}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic br;
            logic rv;
            br = ($urandom % 10) == 0;
            rv = m_out && (($urandom % 2) == 1);
            tick(br, $urandom, ($urandom % 8) != 0, ($urandom % 3) != 0, rv, ($urandom % 5) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/zeroriscy_fetch_ctrl.md
# zeroriscy_fetch_ctrl

Instruction-fetch sequencer that drives the core's 32-bit instruction memory port and fills the fetch FIFO. It generates word-aligned fetch addresses, keeps at most one memory transaction outstanding, discards responses that belong to a fetch stream abandoned by a branch, and pushes each valid response word with its address into the FIFO. It sits between the IF stage's branch/enable controls, the instruction memory interface and the fetch FIFO input port.

## Interface
- No parameters.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable; 0 stops issuing new requests, and any outstanding transaction still completes.
- branch_i  in  1  one-cycle pulse that redirects fetch to addr_i.
- addr_i  in  32  branch target; bit 1 may be set (compressed target), bit 0 ignored.
- busy_o  out  1  1 when state is not IDLE.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  32  memory address, always {x[31:2],2'b00}.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  response data valid, at least 1 cycle after the grant.
- instr_rdata_i  in  32  response data.
- fifo_ready_i  in  1  FIFO has at least 2 free entries.
- fifo_clear_o  out  1  flush FIFO; equals branch_i.
- fifo_valid_o  out  1  push rdata/addr this cycle.
- fifo_addr_o  out  32  address of pushed word: the branch target with bit 1 kept for the first word after a branch, word-aligned afterwards.
- fifo_rdata_o  out  32  equals instr_rdata_i.

## Operation
- Registers: state, fetch_addr (32, full address of the current/next request incl. bit 1), rsp_addr (32, address of the outstanding transaction).
- Next sequential address: {fetch_addr[31:2],2'b00}+4. It is modulo 2^32, so 0xFFFF_FFFC is followed by 0x0000_0000. Bit 1 is cleared.
- Effective address this cycle: addr_i when branch_i is 1, else fetch_addr. instr_addr_o = {eff[31:2],2'b00}.
- Request allowed: branch_i, or req_i & fifo_ready_i.
- IDLE: instr_req_o = allowed. On grant, rsp_addr <= eff, fetch_addr <= eff+4 aligned, go to WAIT_RVALID. With no grant and a request, fetch_addr <= eff and go to WAIT_GNT.
- WAIT_GNT: instr_req_o = 1. The address is held, unless branch_i retargets it in the same cycle; the memory accepts a retarget before grant. On grant, go to WAIT_RVALID (same updates as IDLE).
- WAIT_RVALID, no branch:
  - On rvalid, fifo_valid_o = 1 and fifo_addr_o = rsp_addr.
  - In the same cycle, instr_req_o = allowed. A grant keeps the state WAIT_RVALID. A request with no grant goes to WAIT_GNT. No request goes to IDLE.
  - Without rvalid, instr_req_o = 0.
- WAIT_RVALID with branch_i:
  - fetch_addr <= addr_i.
  - With rvalid in the same cycle, the data is dropped (fifo_valid_o = 0) and the branch request is issued as in IDLE.
  - Without rvalid, go to WAIT_ABORTED and keep instr_req_o = 0.
- WAIT_ABORTED: instr_req_o = 0 until rvalid. The rvalid data is dropped. In the rvalid cycle, request fetch_addr as in IDLE (request forced, since the target is pending). A further branch_i in this state only updates fetch_addr.
- fifo_clear_o = branch_i in every state; a same-cycle push is suppressed.

## Timing
- Reset values: state IDLE, fetch_addr 0, rsp_addr 0. Outputs: instr_req_o 0, fifo_valid_o 0, fifo_clear_o 0, busy_o 0. instr_addr_o and fifo_addr_o are 0 when branch_i is 0.
- No fetch occurs after reset until the first branch_i (boot address).
- Branch to request latency is 0 cycles when no response is outstanding: instr_req_o is asserted in the branch_i cycle.
- rvalid to FIFO push latency is 0 cycles (combinational). Back-to-back grant/rvalid sustains 1 word per cycle.
- At most one outstanding transaction. fifo_ready_i guarantees a free slot for it.
- Reset asserted mid-transaction returns to IDLE immediately. A late rvalid after reset release is ignored in IDLE.

## Test plan
- Reset, then branch_i with addr_i=0x80: request 0x80 in the branch cycle. With gnt/rvalid every cycle, pushes have addr 0x80, 0x84, 0x88.
- branch_i with addr_i=0x102: instr_addr_o=0x100. The first push has fifo_addr_o=0x102, the next 0x104.
- Branch while in WAIT_RVALID, rvalid 3 cycles later: no push for the old word. Request to the target occurs in the rvalid cycle, and the first push carries the target address.
- fifo_ready_i=0 for 4 cycles in WAIT_RVALID: the pending word is still pushed, no new request until ready=1, then the address continues at +4.
- instr_gnt_i held low for 5 cycles: instr_req_o and address stay stable. A branch in cycle 3 retargets instr_addr_o in that cycle.
- Sequential fetch at 0xFFFFFFFC: the next request address is 0x00000000.
